// File: rtl/select_max_par.sv
// select_max_par: arg-max over a snapshotted array of signed scores, LANES scores compared per cycle.
// Latency: ceil(NUM_CLASSES/LANES) edges after the start edge; result held while enable stays high.
// Optional macro SELECT_MAX_RUNNER_UP_EN adds runner-up value/index and best-minus-second margin.
module select_max_par #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int LANES       = 1,
  parameter int DIGIT_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic signed [DATA_W-1:0]  in_data [NUM_CLASSES],
  output logic [DIGIT_W-1:0]        digit,
  output logic signed [DATA_W-1:0]  max,
  output logic                      layer_done,
  output logic                      busy
`ifdef SELECT_MAX_RUNNER_UP_EN
  ,
  output logic signed [DATA_W-1:0]  second,
  output logic [DIGIT_W-1:0]        second_digit,
  output logic signed [DATA_W:0]    margin
`endif
);

  // Pointer must reach past the last element by up to LANES-1 without wrapping.
  localparam int PTR_W = $clog2(NUM_CLASSES + LANES + 1);
  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                     state_q;
  logic [PTR_W-1:0]           ptr_q;
  logic signed [DATA_W-1:0]   snap_q [NUM_CLASSES];
  logic signed [DATA_W-1:0]   best_val_q, best_val_d;
  logic [DIGIT_W-1:0]         best_idx_q, best_idx_d;
  logic [DIGIT_W-1:0]         digit_q;
  logic signed [DATA_W-1:0]   max_q;
  logic                       layer_done_q;
  logic                       busy_q;
  logic [PTR_W-1:0]           ptr_nxt;
  logic                       last_beat;
  logic [PTR_W-1:0]           pos;
  logic signed [DATA_W-1:0]   cand;

`ifdef SELECT_MAX_RUNNER_UP_EN
  logic signed [DATA_W-1:0]   sec_val_q, sec_val_d;
  logic [DIGIT_W-1:0]         sec_idx_q, sec_idx_d;
  logic                       sec_vld_q, sec_vld_d;
  logic signed [DATA_W-1:0]   second_q;
  logic [DIGIT_W-1:0]         second_digit_q;
  logic signed [DATA_W:0]     margin_q;
`endif

  // Final scan beat: this cycle's lanes cover the last element.
  always_comb begin
    ptr_nxt   = ptr_q + PTR_W'(LANES);
    last_beat = (ptr_nxt >= PTR_W'(NUM_CLASSES));
  end

  // Fold this cycle's lanes into the running best in ascending index order;
  // strict > keeps the lowest index on ties.
  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    pos        = '0;
    cand       = '0;
`ifdef SELECT_MAX_RUNNER_UP_EN
    sec_val_d  = sec_val_q;
    sec_idx_d  = sec_idx_q;
    sec_vld_d  = sec_vld_q;
`endif
    for (int l = 0; l < LANES; l++) begin
      pos = ptr_q + PTR_W'(l);
      if (pos < PTR_W'(NUM_CLASSES)) begin
        cand = snap_q[pos[IDX_W-1:0]];
        if (cand > best_val_d) begin
`ifdef SELECT_MAX_RUNNER_UP_EN
          // Element 0 replaces only the seed value, not a real score.
          if (pos != '0) begin
            sec_val_d = best_val_d;
            sec_idx_d = best_idx_d;
            sec_vld_d = 1'b1;
          end
`endif
          best_val_d = cand;
          best_idx_d = DIGIT_W'(pos);
        end
`ifdef SELECT_MAX_RUNNER_UP_EN
        else if ((pos != '0) && (!sec_vld_d || (cand > sec_val_d))) begin
          sec_val_d = cand;
          sec_idx_d = DIGIT_W'(pos);
          sec_vld_d = 1'b1;
        end
`endif
      end
    end
  end

  // Input snapshot taken on the start edge; contents are don't-care until then.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && enable) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        snap_q[c] <= in_data[c];
      end
    end
  end

  // Control FSM with registered outputs; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      best_val_q     <= MIN_VAL;
      best_idx_q     <= '0;
      digit_q        <= '0;
      max_q          <= '0;
      layer_done_q   <= 1'b0;
      busy_q         <= 1'b0;
`ifdef SELECT_MAX_RUNNER_UP_EN
      sec_val_q      <= MIN_VAL;
      sec_idx_q      <= '0;
      sec_vld_q      <= 1'b0;
      second_q       <= '0;
      second_digit_q <= '0;
      margin_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            ptr_q      <= '0;
            best_val_q <= MIN_VAL;
            best_idx_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= SCAN;
`ifdef SELECT_MAX_RUNNER_UP_EN
            sec_val_q  <= MIN_VAL;
            sec_idx_q  <= '0;
            sec_vld_q  <= 1'b0;
`endif
          end
        end
        SCAN: begin
          if (!enable) begin
            // Abort: previous digit/max stay visible.
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            ptr_q      <= ptr_nxt;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
`ifdef SELECT_MAX_RUNNER_UP_EN
            sec_val_q  <= sec_val_d;
            sec_idx_q  <= sec_idx_d;
            sec_vld_q  <= sec_vld_d;
`endif
            if (last_beat) begin
              digit_q        <= best_idx_d;
              max_q          <= best_val_d;
              layer_done_q   <= 1'b1;
              busy_q         <= 1'b0;
              state_q        <= DONE;
`ifdef SELECT_MAX_RUNNER_UP_EN
              second_q       <= sec_val_d;
              second_digit_q <= sec_idx_d;
              margin_q       <= {best_val_d[DATA_W-1], best_val_d}
                              - {sec_val_d[DATA_W-1], sec_val_d};
`endif
            end
          end
        end
        DONE: begin
          // Holding enable high never restarts; it must drop first.
          if (!enable) begin
            layer_done_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign digit      = digit_q;
  assign max        = max_q;
  assign layer_done = layer_done_q;
  assign busy       = busy_q;
`ifdef SELECT_MAX_RUNNER_UP_EN
  assign second       = second_q;
  assign second_digit = second_digit_q;
  assign margin       = margin_q;
`endif

endmodule

// File: tb/tb_select_max_par.sv
// Bench for select_max_par: three instances (LANES = 1, 4, 10) share stimulus;
// expected results are queued at start and popped by a per-instance monitor
// whenever layer_done rises.
module tb_select_max_par;

  localparam int N    = 10;
  localparam int W    = 16;
  localparam int ND   = 3;
  localparam int MINV = -32768;

  typedef struct {
    int digit;
    int val;
    int sdig;
    int sval;
    int s;
  } exp_t;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
  logic signed [W-1:0] in_data [N];

  logic [7:0]          digit_w [ND];
  logic signed [W-1:0] max_w   [ND];
  logic                done_w  [ND];
  logic                busy_w  [ND];
`ifdef SELECT_MAX_RUNNER_UP_EN
  logic signed [W-1:0] second_w [ND];
  logic [7:0]          sdig_w   [ND];
  logic signed [W:0]   margin_w [ND];
`endif

  int   vals [N];
  exp_t exp_q [ND][$];
  int   last_dig [ND];
  int   last_max [ND];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  function automatic int lanes_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 10);
  endfunction

  function automatic int s_of(input int d);
    return (N + lanes_of(d) - 1) / lanes_of(d);
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s [lanes=%0d]: got %0d expected %0d", nm, lanes_of(d), act, exp);
    end
  endtask

  // Reference: max value, lowest index holding it; runner-up is the largest
  // of the remaining indices, lowest index on ties.
  function automatic exp_t ref_model(input int d);
    exp_t e;
    int   best;
    int   sec;
    best   = MINV;
    e.digit = 0;
    for (int i = 0; i < N; i++) if (vals[i] > best) best = vals[i];
    for (int i = N - 1; i >= 0; i--) if (vals[i] == best) e.digit = i;
    e.val  = best;
    sec    = MINV - 1;
    e.sdig = -1;
    for (int i = 0; i < N; i++) begin
      if (i != e.digit && vals[i] > sec) begin
        sec    = vals[i];
        e.sdig = i;
      end
    end
    e.sval = sec;
    e.s    = s_of(d);
    return e;
  endfunction

  for (genvar d = 0; d < ND; d++) begin : g_dut
    select_max_par #(
      .NUM_CLASSES(N),
      .DATA_W     (W),
      .LANES      ((d == 0) ? 1 : ((d == 1) ? 4 : 10)),
      .DIGIT_W    (8)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .in_data     (in_data),
      .digit       (digit_w[d]),
      .max         (max_w[d]),
      .layer_done  (done_w[d]),
      .busy        (busy_w[d])
`ifdef SELECT_MAX_RUNNER_UP_EN
      ,
      .second      (second_w[d]),
      .second_digit(sdig_w[d]),
      .margin      (margin_w[d])
`endif
    );

    int   bcnt      = 0;
    logic prev_done = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
      if (done_w[d] && !prev_done) begin
        if (exp_q[d].size() == 0) begin
          chk("unexpected_done", d, 1, 0);
        end else begin
          cur = exp_q[d].pop_front();
          chk("digit", d, int'(digit_w[d]), cur.digit);
          chk("max", d, int'(max_w[d]), cur.val);
          chk("busy_cycles", d, bcnt, cur.s);
`ifdef SELECT_MAX_RUNNER_UP_EN
          chk("second", d, int'(second_w[d]), cur.sval);
          chk("second_digit", d, int'(sdig_w[d]), cur.sdig);
          chk("margin", d, int'(margin_w[d]), cur.val - cur.sval);
`endif
        end
      end else if (done_w[d] && prev_done) begin
        chk("held_digit", d, int'(digit_w[d]), cur.digit);
        chk("held_max", d, int'(max_w[d]), cur.val);
      end
      if (busy_w[d]) bcnt++;
      else if (!done_w[d]) bcnt = 0;
      prev_done = done_w[d];
    end
  end

  task automatic drive_vals();
    for (int i = 0; i < N; i++) in_data[i] = W'(vals[i]);
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
  endtask

  task automatic fill(input int pat);
    int c;
    c = int'($urandom_range(0, 65535)) - 32768;
    for (int i = 0; i < N; i++) begin
      case (pat)
        0:       vals[i] = int'($urandom_range(0, 65535)) - 32768;
        1:       vals[i] = int'($urandom_range(0, 6)) - 3;
        2:       vals[i] = c;
        3:       vals[i] = MINV;
        default: vals[i] = int'($urandom_range(0, 200)) - 100;
      endcase
    end
    if (pat == 4) vals[$urandom_range(0, N - 1)] = 32767;
  endtask

  task automatic post_checks(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_busy"}, d, busy_w[d], 0);
      chk({tag, "_done"}, d, done_w[d], 0);
      chk({tag, "_digit"}, d, int'(digit_w[d]), last_dig[d]);
      chk({tag, "_max"}, d, int'(max_w[d]), last_max[d]);
      chk({tag, "_pending"}, d, exp_q[d].size(), 0);
      exp_q[d].delete();
    end
  endtask

  // abort_at = 0: run to completion; otherwise enable is low at edge start+abort_at.
  task automatic scan(input int abort_at, input int hold);
    exp_t e [ND];
    bit   comp [ND];
    drive_vals();
    enable = 1'b1;
    for (int d = 0; d < ND; d++) begin
      e[d]    = ref_model(d);
      comp[d] = (abort_at == 0) || (abort_at > e[d].s);
      if (comp[d]) exp_q[d].push_back(e[d]);
    end
    @(negedge clk);
    scramble();
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
    end else begin
      repeat (s_of(0)) @(negedge clk);
      for (int d = 0; d < ND; d++) chk("done_at_latency", d, done_w[d], 1);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
          chk("hold_done", d, done_w[d], 1);
          chk("hold_busy", d, busy_w[d], 0);
        end
      end
      enable = 1'b0;
      @(negedge clk);
    end
    for (int d = 0; d < ND; d++) begin
      if (comp[d]) begin
        last_dig[d] = e[d].digit;
        last_max[d] = e[d].val;
      end
    end
    post_checks(abort_at > 0 ? "abort" : "release");
  endtask

  task automatic reset_mid_scan();
    fill(0);
    drive_vals();
    enable = 1'b1;
    for (int d = 0; d < ND; d++) if (s_of(d) < 5) exp_q[d].push_back(ref_model(d));
    @(negedge clk);
    scramble();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("rst_digit", d, int'(digit_w[d]), 0);
      chk("rst_max", d, int'(max_w[d]), 0);
      chk("rst_done", d, done_w[d], 0);
      chk("rst_busy", d, busy_w[d], 0);
      last_dig[d] = 0;
      last_max[d] = 0;
    end
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    post_checks("after_rst");
  endtask

  initial begin
    int ab;
    for (int i = 0; i < N; i++) in_data[i] = '0;
    for (int d = 0; d < ND; d++) begin
      last_dig[d] = 0;
      last_max[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("init_digit", d, int'(digit_w[d]), 0);
      chk("init_max", d, int'(max_w[d]), 0);
      chk("init_done", d, done_w[d], 0);
      chk("init_busy", d, busy_w[d], 0);
`ifdef SELECT_MAX_RUNNER_UP_EN
      chk("init_second", d, int'(second_w[d]), 0);
      chk("init_second_digit", d, int'(sdig_w[d]), 0);
      chk("init_margin", d, int'(margin_w[d]), 0);
`endif
    end
    reset = 1'b0;
    @(negedge clk);

    vals = '{0, 0, 5, 85, 0, 10, 0, 0, 0, 0};
    scan(0, 3);
    for (int i = 0; i < N; i++) vals[i] = 7;
    scan(0, 1);
    fill(3);
    scan(0, 0);
    for (int i = 0; i < N; i++) vals[i] = -5;
    vals[9] = 300;
    scan(0, 2);

    vals = '{0, 0, 5, 85, 0, 10, 0, 0, 0, 0};
    scan(0, 0);
    fill(0);
    scan(4, 0);

    reset_mid_scan();
    vals = '{0, 0, 5, 85, 0, 10, 0, 0, 0, 0};
    scan(0, 1);

    repeat (40) begin
      fill(int'($urandom_range(0, 4)));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 0;
      scan(ab, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/select_max_par.md
SELECT_MAX_PAR -- requirements
Module: select_max_par

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of signed scores scanned; SHALL be >= 2.
REQ-002 Parameter DATA_W, default 16, score width in bits (two's complement).
REQ-003 Parameter LANES, default 1, scores compared per cycle; SHALL satisfy 1 <= LANES <= NUM_CLASSES.
REQ-004 Parameter DIGIT_W, default 8, index output width; SHALL be >= clog2(NUM_CLASSES).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  start/hold request, level-sensitive.
REQ-008 in_data  input  NUM_CLASSES x DATA_W signed  score array, element 0 = class 0.
REQ-009 digit  output  DIGIT_W  index of maximum score.
REQ-010 max  output  DATA_W signed  maximum score value.
REQ-011 layer_done  output  1  result valid.
REQ-012 busy  output  1  scan in progress.

Function
REQ-013 FSM states SHALL be IDLE, SCAN, DONE; IDLE after reset.
REQ-014 IDLE, enable=1 at edge: snapshot all of in_data into an internal buffer, best value = -2^(DATA_W-1), best index = 0, pointer = 0, go SCAN; in_data is ignored afterwards until the next start.
REQ-015 SCAN, each edge: compare snapshot elements pointer..pointer+LANES-1 (indices >= NUM_CLASSES skipped) in ascending index order; replace best only on strictly greater value; pointer += LANES.
REQ-016 Ties SHALL resolve to the lowest index; all-equal inputs (including all -2^(DATA_W-1)) SHALL give digit 0.
REQ-017 SCAN SHALL last S = ceil(NUM_CLASSES/LANES) edges; on the S-th, digit/max SHALL load the final best and FSM go DONE, so layer_done is high after edge k+S where k is the starting edge (N=10, LANES=1: 11 edges total).
REQ-018 busy SHALL be 1 exactly while in SCAN.
REQ-019 DONE: layer_done=1, digit/max held, for as long as enable=1; enable=0 at edge -> IDLE, layer_done=0 next cycle, digit/max retained.
REQ-020 A new scan SHALL require enable to return low; enable held high never restarts.
REQ-021 enable=0 during SCAN SHALL abort to IDLE at that edge; layer_done stays 0, digit/max keep previous result.
REQ-022 Comparisons SHALL be signed, full DATA_W, no saturation or truncation.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, digit=0, max=0, layer_done=0, busy=0, pointer=0, from any state including mid-SCAN; reset has priority over enable.
REQ-024 Snapshot buffer contents need not be cleared by reset.

Configuration
REQ-025 Macro SELECT_MAX_RUNNER_UP_EN, when defined, SHALL add outputs second (DATA_W signed), second_digit (DIGIT_W) and margin (DATA_W+1 signed = max - second), all reset to 0 and valid with layer_done.
REQ-026 Runner-up SHALL be the largest score among indices other than digit, ties to lowest index; on a new best the old best becomes runner-up; if not defined these ports and their logic SHALL be absent and all other behaviour unchanged.

Verification
REQ-027 N=10, LANES=1, in_data {0,0,5,85,0,10,0,0,0,0}, enable held -> digit=3, max=85, layer_done high after 11th edge and held; with macro second=10, second_digit=5, margin=75.
REQ-028 All scores 7 -> digit=0, max=7; all -32768 -> digit=0, max=-32768; with macro second_digit=1, margin=0.
REQ-029 LANES=4, N=10, max value 300 at index 9, others -5 -> busy high 3 cycles, digit=9, max=300; repeat with LANES=10 -> busy 1 cycle, same result.
REQ-030 Change in_data to put 500 at index 0 one cycle after start -> result unaffected (digit=3, max=85).
REQ-031 reset pulsed during 5th SCAN cycle -> next cycle IDLE, all outputs 0; enable low then high -> normal completion.
REQ-032 enable dropped at 4th SCAN cycle after a prior result digit=3 -> layer_done stays 0, digit=3 retained, busy=0 next cycle.
